// File: rtl/apb_cfg_completer_if.sv
// APB3 bus bundle between the uDMA APB initiator and the configuration completer.
interface apb_cfg_completer_if;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic        pwrite;
  logic        psel;
  logic        penable;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport master (
    output paddr, pwdata, pwrite, psel, penable,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  paddr, pwdata, pwrite, psel, penable,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_cfg_completer.sv
// APB3 completer holding uDMA clock-gate enables, sticky protocol status and per-channel
// configuration words, with programmable wait states and protocol-violation detection.
module apb_cfg_completer #(
  parameter int unsigned NUM_PERIPH  = 8,
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  apb_cfg_completer_if.slave         apb,
  output logic [NUM_PERIPH-1:0]      cg_en_o,
  output logic [NUM_PERIPH*32-1:0]   periph_cfg_o,
  output logic [NUM_PERIPH-1:0]      cfg_wr_o
);

  typedef enum logic [0:0] {StIdle, StAccess} state_e;

  localparam logic [ADDR_WIDTH-1:0] AddrCgEn   = '0;
  localparam logic [ADDR_WIDTH-1:0] AddrStatus = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] CfgBase    = ADDR_WIDTH'(128);

  state_e                       state_q, state_d;
  logic [3:0]                   cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]        addr_q;
  logic                         write_q;
  logic [31:0]                  wdata_q;
  logic [NUM_PERIPH-1:0]        cg_en_q;
  logic [NUM_PERIPH-1:0]        cfg_wr_q;
  logic [NUM_PERIPH-1:0][31:0]  cfg_q;
  logic                         prot_err_q;

  logic                         setup, complete, wr_en;
  logic                         sel_cg, sel_st, dec_err;
  logic                         prot_set, prot_clr;
  logic [NUM_PERIPH-1:0]        cfg_hit;
  logic [31:0]                  rdata;
  logic                         unused_paddr_hi;

  assign unused_paddr_hi = ^apb.paddr[31:ADDR_WIDTH];

  assign setup    = (state_q == StIdle) && apb.psel && !apb.penable;
  assign complete = (state_q == StAccess) && apb.psel && apb.penable && (cnt_q == 4'd0);
  assign wr_en    = complete && write_q && !dec_err;

  // Protocol violations: access phase without setup, or psel dropped mid-transfer.
  assign prot_set = ((state_q == StIdle) && apb.psel && apb.penable) ||
                    ((state_q == StAccess) && !apb.psel);
  assign prot_clr = wr_en && sel_st && wdata_q[0];

  assign sel_cg  = (addr_q == AddrCgEn);
  assign sel_st  = (addr_q == AddrStatus);
  assign dec_err = !(sel_cg || sel_st || (|cfg_hit));

  always_comb begin
    cfg_hit = '0;
    rdata   = '0;
    for (int unsigned i = 0; i < NUM_PERIPH; i++) begin
      cfg_hit[i] = (addr_q == CfgBase + ADDR_WIDTH'(4 * i));
      if (cfg_hit[i]) rdata = cfg_q[i];
    end
    if (sel_cg) rdata = 32'(cg_en_q);
    if (sel_st) rdata = {31'b0, prot_err_q};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (setup) begin
          state_d = StAccess;
          cnt_d   = 4'(WAIT_CYCLES);
        end
      end
      StAccess: begin
        if (!apb.psel) begin
          state_d = StIdle;
        end else if (apb.penable) begin
          if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
          else               state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    apb.pready  = 1'b0;
    apb.pslverr = 1'b0;
    apb.prdata  = '0;
    if (complete) begin
      apb.pready  = 1'b1;
      apb.pslverr = dec_err;
      apb.prdata  = dec_err ? 32'h0 : rdata;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q     <= '0;
      write_q    <= 1'b0;
      wdata_q    <= '0;
      cg_en_q    <= '0;
      cfg_wr_q   <= '0;
      cfg_q      <= '0;
      prot_err_q <= 1'b0;
    end else begin
      if (setup) begin
        addr_q  <= apb.paddr[ADDR_WIDTH-1:0];
        write_q <= apb.pwrite;
        wdata_q <= apb.pwdata;
      end
      cfg_wr_q <= wr_en ? cfg_hit : '0;
      if (wr_en && sel_cg) cg_en_q <= wdata_q[NUM_PERIPH-1:0];
      for (int unsigned i = 0; i < NUM_PERIPH; i++) begin
        if (wr_en && cfg_hit[i]) cfg_q[i] <= wdata_q;
      end
      // A violation in the same cycle as a W1C keeps the flag set.
      prot_err_q <= prot_set | (prot_err_q & ~prot_clr);
    end
  end

  assign cg_en_o      = cg_en_q;
  assign periph_cfg_o = cfg_q;
  assign cfg_wr_o     = cfg_wr_q;

endmodule

// File: tb/tb_apb_cfg_completer.sv
// Scoreboard bench: one completer with one wait state, one with zero wait states.
module tb_apb_cfg_completer;

  typedef struct {
    string       tag;
    logic [31:0] rdata;
    logic        err;
    logic        is_rd;
    int          cycles;
  } exp_t;

  logic         clk, rst;
  logic [7:0]   cg_en1, cg_en0, cfg_wr1, cfg_wr0;
  logic [255:0] cfg1, cfg0;
  exp_t         sb[$];
  int           errors = 0;
  int           checks = 0;

  apb_cfg_completer_if bus1 ();
  apb_cfg_completer_if bus0 ();

  apb_cfg_completer #(.NUM_PERIPH(8), .ADDR_WIDTH(12), .WAIT_CYCLES(1)) u_dut_w1 (
    .clk_i(clk), .rst_i(rst), .apb(bus1),
    .cg_en_o(cg_en1), .periph_cfg_o(cfg1), .cfg_wr_o(cfg_wr1)
  );

  apb_cfg_completer #(.NUM_PERIPH(8), .ADDR_WIDTH(12), .WAIT_CYCLES(0)) u_dut_w0 (
    .clk_i(clk), .rst_i(rst), .apb(bus0),
    .cg_en_o(cg_en0), .periph_cfg_o(cfg0), .cfg_wr_o(cfg_wr0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic drive(input bit fast, input logic sel, input logic en, input logic [31:0] addr,
                       input logic wr, input logic [31:0] wdata);
    if (fast) begin
      bus0.psel = sel; bus0.penable = en; bus0.paddr = addr; bus0.pwrite = wr;
      bus0.pwdata = wdata;
    end else begin
      bus1.psel = sel; bus1.penable = en; bus1.paddr = addr; bus1.pwrite = wr;
      bus1.pwdata = wdata;
    end
  endtask

  function automatic logic rdy_of(input bit fast);
    return fast ? bus0.pready : bus1.pready;
  endfunction

  function automatic logic err_of(input bit fast);
    return fast ? bus0.pslverr : bus1.pslverr;
  endfunction

  function automatic logic [31:0] rd_of(input bit fast);
    return fast ? bus0.prdata : bus1.prdata;
  endfunction

  // Full transfer; pwdata is scrambled during the access phase to prove it was latched.
  task automatic xfer(input bit fast, input logic [31:0] addr, input logic wr,
                      input logic [31:0] wdata, input logic [31:0] rdata, input logic err,
                      input int cycles, input bit keep, input string tag);
    exp_t e;
    int   n;
    e.tag = tag; e.rdata = rdata; e.err = err; e.is_rd = !wr; e.cycles = cycles;
    @(posedge clk); #1;
    drive(fast, 1'b1, 1'b0, addr, wr, wdata);
    sb.push_back(e);
    @(posedge clk); #1;
    drive(fast, 1'b1, 1'b1, addr, wr, ~wdata);
    n = 1;
    forever begin
      @(negedge clk);
      if (rdy_of(fast)) begin
        e = sb.pop_front();
        check({e.tag, "_err"}, err_of(fast), e.err);
        if (e.is_rd) check({e.tag, "_rdata"}, rd_of(fast), e.rdata);
        check({e.tag, "_cycles"}, n, e.cycles);
        break;
      end
      if (n >= 20) begin
        e = sb.pop_front();
        check({e.tag, "_timeout"}, n, e.cycles);
        break;
      end
      n++;
      @(posedge clk); #1;
    end
    if (!keep) begin
      @(posedge clk); #1;
      drive(fast, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_pready", bus1.pready, 1'b0);
    check("rst_cg_en", cg_en1, 8'h0);
    check("rst_cfg", cfg1, 256'h0);
    check("rst_cfg_wr", cfg_wr1, 8'h0);
    #1 rst = 1'b0;

    xfer(1'b0, 32'h000, 1'b0, 32'h0, 32'h0, 1'b0, 2, 1'b0, "rd_cgen0");
    xfer(1'b0, 32'h004, 1'b0, 32'h0, 32'h0, 1'b0, 2, 1'b0, "rd_status0");
    xfer(1'b0, 32'h080, 1'b0, 32'h0, 32'h0, 1'b0, 2, 1'b0, "rd_cfg0");

    xfer(1'b0, 32'h000, 1'b1, 32'hFFFF_FFFF, 32'h0, 1'b0, 2, 1'b0, "wr_cgen");
    check("cg_en_ff", cg_en1, 8'hFF);
    xfer(1'b0, 32'h000, 1'b0, 32'h0, 32'h0000_00FF, 1'b0, 2, 1'b0, "rd_cgen_ff");

    xfer(1'b0, 32'h084, 1'b1, 32'hDEAD_BEEF, 32'h0, 1'b0, 2, 1'b0, "wr_cfg1");
    check("cfg_wr_pulse", cfg_wr1, 8'h02);
    check("cfg1_val", cfg1[63:32], 32'hDEAD_BEEF);
    @(posedge clk); #1;
    check("cfg_wr_end", cfg_wr1, 8'h00);
    xfer(1'b0, 32'h084, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b0, 2, 1'b0, "rd_cfg1");

    xfer(1'b0, 32'h0A0, 1'b0, 32'h0, 32'h0, 1'b1, 2, 1'b0, "rd_unmapped");
    xfer(1'b0, 32'h082, 1'b1, 32'h1234_5678, 32'h0, 1'b1, 2, 1'b0, "wr_misaligned");
    check("err_cfg_wr", cfg_wr1, 8'h00);
    check("err_cfg", cfg1, {192'h0, 32'hDEAD_BEEF, 32'h0});
    check("err_cg_en", cg_en1, 8'hFF);

    // Abandon a CFG[0] write by dropping psel before pready.
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b0, 32'h080, 1'b1, 32'h5555_AAAA);
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b1, 32'h080, 1'b1, 32'h5555_AAAA);
    @(negedge clk);
    check("abort_wait_pready", bus1.pready, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    check("abort_pready", bus1.pready, 1'b0);
    xfer(1'b0, 32'h080, 1'b0, 32'h0, 32'h0, 1'b0, 2, 1'b0, "rd_cfg0_abort");
    xfer(1'b0, 32'h004, 1'b0, 32'h0, 32'h1, 1'b0, 2, 1'b0, "rd_status_set");
    xfer(1'b0, 32'h004, 1'b1, 32'h1, 32'h0, 1'b0, 2, 1'b0, "w1c_status");
    xfer(1'b0, 32'h004, 1'b0, 32'h0, 32'h0, 1'b0, 2, 1'b0, "rd_status_clr");

    // Zero-wait-state instance, back-to-back with psel held high.
    xfer(1'b1, 32'h000, 1'b1, 32'h0000_00A5, 32'h0, 1'b0, 1, 1'b0, "w0_wr_cgen");
    check("w0_cg_en", cg_en0, 8'hA5);
    xfer(1'b1, 32'h088, 1'b1, 32'hCAFE_F00D, 32'h0, 1'b0, 1, 1'b1, "b2b_wr");
    xfer(1'b1, 32'h088, 1'b0, 32'h0, 32'hCAFE_F00D, 1'b0, 1, 1'b0, "b2b_rd");
    check("w0_cfg2", cfg0[95:64], 32'hCAFE_F00D);

    // Reset during the completing access cycle of a CFG[3] write.
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 1'b0, 32'h08C, 1'b1, 32'hAAAA_5555);
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 1'b1, 32'h08C, 1'b1, 32'hAAAA_5555);
    @(negedge clk);
    check("mid_pready_pre", bus0.pready, 1'b1);
    #1 rst = 1'b1;
    #1;
    check("mid_pready", bus0.pready, 1'b0);
    check("mid_pslverr", bus0.pslverr, 1'b0);
    check("mid_prdata", bus0.prdata, 32'h0);
    check("mid_cg_en", cg_en0, 8'h0);
    check("mid_cfg", cfg0, 256'h0);
    check("mid_cfg_wr", cfg_wr0, 8'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    xfer(1'b1, 32'h08C, 1'b0, 32'h0, 32'h0, 1'b0, 1, 1'b0, "rd_cfg3_dropped");
    xfer(1'b1, 32'h004, 1'b0, 32'h0, 32'h0, 1'b0, 1, 1'b0, "rd_status_post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
